// File: rtl/cmsdk_ahb_sram_bridge.sv
// AHB-Lite slave to cmsdk_fpga_sram; zero-wait reads, data-phase writes with a 1-entry write buffer.
// Latency: read data one cycle after the address phase; HREADYOUT stays 1 except in the ERROR response.
// Optional alignment checking under CMSDK_AHB_SRAM_ALIGN_ERR_EN (two-cycle ERROR, no SRAM access).
module cmsdk_ahb_sram_bridge #(
  parameter int AW = 16
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          HSEL,
  input  logic          HREADY,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic [AW-1:0] HADDR,
  input  logic [31:0]   HWDATA,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  output logic [AW-3:0] SRAMADDR,
  output logic [31:0]   SRAMWDATA,
  output logic [3:0]    SRAMWEN,
  output logic          SRAMCS,
  input  logic [31:0]   SRAMRDATA
);

  // Only NONSEQ/SEQ matter; bit 0 distinguishes them and carries no meaning here.
  logic unused_htrans;
  assign unused_htrans = HTRANS[0];

  logic          acc_raw;
  logic          acc;
  logic          rd_acc;
  logic          wr_acc;
  logic [3:0]    be;

  logic          wr_dph;
  logic [AW-3:0] wr_addr_q;
  logic [3:0]    wr_be_q;
  logic          rd_dph;
  logic [AW-3:0] rd_addr_q;
  logic          buf_vld;
  logic [AW-3:0] buf_addr;
  logic [3:0]    buf_be;
  logic [31:0]   buf_data;
  logic [31:0]   merged;
  logic          fwd_hit;

  // Nothing is accepted while reset is asserted, so no SRAM action can start during reset.
  assign acc_raw = HSEL & HREADY & HTRANS[1] & ~HRESET;

`ifdef CMSDK_AHB_SRAM_ALIGN_ERR_EN
  typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} err_state_t;

  err_state_t err_state;
  logic       unaligned;
  logic       err_acc;
  logic       hreadyout_q;
  logic       hresp_q;

  assign unaligned = ((HSIZE == 3'd1) & HADDR[0]) |
                     ((HSIZE == 3'd2) & (|HADDR[1:0])) |
                     (HSIZE > 3'd2);
  assign err_acc   = acc_raw & unaligned;
  assign acc       = acc_raw & ~unaligned;

  // Two-cycle ERROR response sequencer; an accepted transfer in ERR2 is handled like one in IDLE.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      err_state   <= ST_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      case (err_state)
        ST_ERR1: begin
          err_state   <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        default: begin
          if (err_acc) begin
            err_state   <= ST_ERR1;
            hreadyout_q <= 1'b0;
            hresp_q     <= 1'b1;
          end else begin
            err_state   <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end
      endcase
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
`else
  // Unaligned addresses simply select byte lanes; the bus never sees an error.
  assign acc       = acc_raw;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
`endif

  assign rd_acc = acc & ~HWRITE;
  assign wr_acc = acc & HWRITE;

  // Byte lanes touched by the transfer in its address phase.
  always_comb begin
    case (HSIZE)
      3'd0:    be = 4'b0001 << HADDR[1:0];
      3'd1:    be = HADDR[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Pipeline valid flags and the write buffer occupancy.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_dph  <= 1'b0;
      rd_dph  <= 1'b0;
      buf_vld <= 1'b0;
    end else begin
      wr_dph <= wr_acc;
      rd_dph <= rd_acc;
      if (wr_dph && rd_acc) begin
        buf_vld <= 1'b1;
      end else if (buf_vld && !wr_dph && !rd_acc) begin
        buf_vld <= 1'b0;
      end
    end
  end

  // Address/lane/data capture; these only matter while the matching valid flag is set.
  always_ff @(posedge HCLK) begin
    if (wr_acc) begin
      wr_addr_q <= HADDR[AW-1:2];
      wr_be_q   <= be;
    end
    if (rd_acc) begin
      rd_addr_q <= HADDR[AW-1:2];
    end
    if (wr_dph && rd_acc) begin
      buf_addr <= wr_addr_q;
      buf_be   <= wr_be_q;
      buf_data <= HWDATA;
    end
  end

  // One SRAM action per cycle: read, then direct write, then buffer drain.
  always_comb begin
    SRAMCS    = 1'b0;
    SRAMWEN   = 4'b0000;
    SRAMADDR  = buf_addr;
    SRAMWDATA = buf_data;
    if (!HRESET) begin
      if (rd_acc) begin
        SRAMCS   = 1'b1;
        SRAMADDR = HADDR[AW-1:2];
      end else if (wr_dph) begin
        SRAMCS    = 1'b1;
        SRAMADDR  = wr_addr_q;
        SRAMWDATA = HWDATA;
        SRAMWEN   = wr_be_q;
      end else if (buf_vld) begin
        SRAMCS    = 1'b1;
        SRAMADDR  = buf_addr;
        SRAMWDATA = buf_data;
        SRAMWEN   = buf_be;
      end
    end
  end

  assign fwd_hit = buf_vld & (buf_addr == rd_addr_q);

  // Read data: SRAM word with lanes still sitting in the write buffer forwarded over it.
  always_comb begin
    merged = SRAMRDATA;
    for (int i = 0; i < 4; i++) begin
      if (fwd_hit && buf_be[i]) begin
        merged[8*i +: 8] = buf_data[8*i +: 8];
      end
    end
    HRDATA = rd_dph ? merged : 32'h0;
  end

  // A buffered write must drain before another write reaches its data phase alongside a read.
  buf_conflict: assert property (@(posedge HCLK) disable iff (HRESET)
                                 !(buf_vld && wr_dph && rd_acc));

endmodule

// File: tb/tb_cmsdk_ahb_sram_bridge.sv
// Directed bench for cmsdk_ahb_sram_bridge with a behavioural cmsdk_fpga_sram model.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
// HREADY is looped back from HREADYOUT and can be forced low.
module tb_cmsdk_ahb_sram_bridge;

  logic        clk = 1'b0;
  logic        hreset;
  logic        hsel;
  logic        hready;
  logic        hready_en;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [15:0] haddr;
  logic [31:0] hwdata;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic [13:0] sramaddr;
  logic [31:0] sramwdata;
  logic [3:0]  sramwen;
  logic        sramcs;
  logic [31:0] sramrdata;

  logic [31:0] mem [0:255];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign hready = hreadyout & hready_en;

  cmsdk_ahb_sram_bridge #(.AW(16)) dut (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel), .HREADY(hready), .HTRANS(htrans),
    .HSIZE(hsize), .HWRITE(hwrite), .HADDR(haddr), .HWDATA(hwdata),
    .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata),
    .SRAMADDR(sramaddr), .SRAMWDATA(sramwdata), .SRAMWEN(sramwen),
    .SRAMCS(sramcs), .SRAMRDATA(sramrdata)
  );

  // SRAM model: byte-lane writes, registered read data.
  always @(posedge clk) begin
    if (sramcs) begin
      for (int i = 0; i < 4; i++) begin
        if (sramwen[i]) mem[sramaddr[7:0]][8*i +: 8] <= sramwdata[8*i +: 8];
      end
      if (sramwen == 4'b0000) sramrdata <= mem[sramaddr[7:0]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic ap(input logic wr, input logic [2:0] sz, input logic [15:0] a);
    hsel = 1'b1; htrans = 2'b10; hwrite = wr; hsize = sz; haddr = a;
  endtask

  task automatic idle();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2; haddr = 16'h0;
  endtask

  task automatic test_reset();
    hreset = 1'b1; hready_en = 1'b1; hwdata = 32'h0; idle();
    tick(); tick();
    mid();
    tests++;
    if ({hreadyout, hresp, sramcs, sramwen} !== 7'b1000000) begin
      fails++; $display("FAIL reset_ctrl got %b exp %b", {hreadyout, hresp, sramcs, sramwen}, 7'b1000000);
    end
    tests++;
    if (hrdata !== 32'h0) begin
      fails++; $display("FAIL reset_hrdata got %h exp %h", hrdata, 32'h0);
    end
    tick();
    hreset = 1'b0;
  endtask

  task automatic test_word_write_read();
    ap(1'b1, 3'd2, 16'h0010);
    mid();
    tests++;
    if (sramcs !== 1'b0) begin
      fails++; $display("FAIL t1_addr_phase_cs got %b exp 0", sramcs);
    end
    tick();
    idle(); hwdata = 32'hDEADBEEF;
    mid();
    tests++;
    if ({sramcs, sramwen, sramaddr, sramwdata} !== {1'b1, 4'hF, 14'h4, 32'hDEADBEEF}) begin
      fails++; $display("FAIL t1_direct_write got cs=%b wen=%h a=%h d=%h exp cs=1 wen=f a=4 d=deadbeef",
                        sramcs, sramwen, sramaddr, sramwdata);
    end
    tick();
    ap(1'b0, 3'd2, 16'h0010);
    mid();
    tests++;
    if ({sramcs, sramwen, sramaddr} !== {1'b1, 4'h0, 14'h4}) begin
      fails++; $display("FAIL t1_read_issue got cs=%b wen=%h a=%h exp cs=1 wen=0 a=4", sramcs, sramwen, sramaddr);
    end
    tick();
    idle();
    mid();
    tests++;
    if (hrdata !== 32'hDEADBEEF) begin
      fails++; $display("FAIL t1_hrdata got %h exp %h", hrdata, 32'hDEADBEEF);
    end
    tick();
  endtask

  task automatic test_buffer_forward();
    ap(1'b1, 3'd0, 16'h0013);
    tick();
    ap(1'b0, 3'd2, 16'h0010); hwdata = 32'hAA112233;
    mid();
    tests++;
    if ({sramcs, sramwen} !== 5'b1_0000) begin
      fails++; $display("FAIL t2_buffered got cs=%b wen=%b exp cs=1 wen=0000", sramcs, sramwen);
    end
    tick();
    idle(); hwdata = 32'h0;
    mid();
    tests++;
    if (hrdata !== 32'hAAADBEEF) begin
      fails++; $display("FAIL t2_forward got %h exp %h", hrdata, 32'hAAADBEEF);
    end
    tests++;
    if ({sramcs, sramwen, sramaddr, sramwdata[31:24]} !== {1'b1, 4'b1000, 14'h4, 8'hAA}) begin
      fails++; $display("FAIL t2_drain got cs=%b wen=%b a=%h d=%h exp cs=1 wen=1000 a=4 d[31:24]=aa",
                        sramcs, sramwen, sramaddr, sramwdata);
    end
    tick();
    ap(1'b0, 3'd2, 16'h0010);
    tick();
    idle();
    mid();
    tests++;
    if (hrdata !== 32'hAAADBEEF) begin
      fails++; $display("FAIL t2_after_drain got %h exp %h", hrdata, 32'hAAADBEEF);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    ap(1'b1, 3'd2, 16'h0020);
    tick();
    ap(1'b1, 3'd2, 16'h0024); hwdata = 32'h11111111;
    mid();
    tests++;
    if ({sramcs, sramwen, sramaddr} !== {1'b1, 4'hF, 14'h8}) begin
      fails++; $display("FAIL t3_w20 got cs=%b wen=%h a=%h exp cs=1 wen=f a=8", sramcs, sramwen, sramaddr);
    end
    tick();
    ap(1'b1, 3'd2, 16'h0028); hwdata = 32'h22222222;
    mid();
    tests++;
    if ({sramcs, sramwen, sramaddr} !== {1'b1, 4'hF, 14'h9}) begin
      fails++; $display("FAIL t3_w24 got cs=%b wen=%h a=%h exp cs=1 wen=f a=9", sramcs, sramwen, sramaddr);
    end
    tick();
    idle(); hwdata = 32'h33333333;
    mid();
    tests++;
    if ({sramcs, sramwen, sramaddr} !== {1'b1, 4'hF, 14'hA}) begin
      fails++; $display("FAIL t3_w28 got cs=%b wen=%h a=%h exp cs=1 wen=f a=a", sramcs, sramwen, sramaddr);
    end
    tick();
    ap(1'b0, 3'd2, 16'h0020);
    tick();
    ap(1'b0, 3'd2, 16'h0024);
    mid();
    tests++;
    if (hrdata !== 32'h11111111) begin
      fails++; $display("FAIL t3_r20 got %h exp %h", hrdata, 32'h11111111);
    end
    tick();
    ap(1'b0, 3'd2, 16'h0028);
    mid();
    tests++;
    if (hrdata !== 32'h22222222) begin
      fails++; $display("FAIL t3_r24 got %h exp %h", hrdata, 32'h22222222);
    end
    tick();
    idle();
    mid();
    tests++;
    if (hrdata !== 32'h33333333) begin
      fails++; $display("FAIL t3_r28 got %h exp %h", hrdata, 32'h33333333);
    end
    tick();
  endtask

  task automatic test_buffer_hold();
    ap(1'b1, 3'd2, 16'h0034);
    tick();
    idle(); hwdata = 32'h12345678;
    tick();
    ap(1'b1, 3'd2, 16'h0030);
    tick();
    ap(1'b0, 3'd2, 16'h0034); hwdata = 32'hCAFEF00D;
    mid();
    tests++;
    if (sramwen !== 4'h0) begin
      fails++; $display("FAIL t4_buffered got wen=%h exp 0", sramwen);
    end
    tick();
    hwdata = 32'h0;
    for (int i = 1; i < 10; i++) begin
      ap(1'b0, 3'd2, 16'h0034);
      mid();
      tests++;
      if ({sramwen, hrdata} !== {4'h0, 32'h12345678}) begin
        fails++; $display("FAIL t4_hold_read%0d got wen=%h d=%h exp wen=0 d=12345678", i, sramwen, hrdata);
      end
      tick();
    end
    idle();
    mid();
    tests++;
    if (hrdata !== 32'h12345678) begin
      fails++; $display("FAIL t4_last_read got %h exp %h", hrdata, 32'h12345678);
    end
    tests++;
    if ({sramcs, sramwen, sramaddr, sramwdata} !== {1'b1, 4'hF, 14'hC, 32'hCAFEF00D}) begin
      fails++; $display("FAIL t4_drain got cs=%b wen=%h a=%h d=%h exp cs=1 wen=f a=c d=cafef00d",
                        sramcs, sramwen, sramaddr, sramwdata);
    end
    tick();
    ap(1'b0, 3'd2, 16'h0030);
    tick();
    idle();
    mid();
    tests++;
    if (hrdata !== 32'hCAFEF00D) begin
      fails++; $display("FAIL t4_r30 got %h exp %h", hrdata, 32'hCAFEF00D);
    end
    tick();
  endtask

  task automatic test_byte_enables();
    ap(1'b1, 3'd2, 16'h0014);
    tick();
    ap(1'b1, 3'd1, 16'h0016); hwdata = 32'h0;
    tick();
    ap(1'b1, 3'd0, 16'h0015); hwdata = 32'hBEEF1234;
    mid();
    tests++;
    if ({sramwen, sramaddr} !== {4'b1100, 14'h5}) begin
      fails++; $display("FAIL be_half got wen=%b a=%h exp wen=1100 a=5", sramwen, sramaddr);
    end
    tick();
    idle(); hwdata = 32'h99995699;
    mid();
    tests++;
    if (sramwen !== 4'b0010) begin
      fails++; $display("FAIL be_byte got wen=%b exp 0010", sramwen);
    end
    tick();
    ap(1'b0, 3'd2, 16'h0014);
    tick();
    idle();
    mid();
    tests++;
    if (hrdata !== 32'hBEEF5600) begin
      fails++; $display("FAIL be_readback got %h exp %h", hrdata, 32'hBEEF5600);
    end
    tick();
  endtask

  task automatic test_not_accepted();
    hready_en = 1'b0;
    ap(1'b1, 3'd2, 16'h0014);
    tick();
    hready_en = 1'b1; idle(); hwdata = 32'hFFFFFFFF;
    mid();
    tests++;
    if ({sramcs, sramwen} !== 5'b0) begin
      fails++; $display("FAIL na_hready got cs=%b wen=%b exp 0", sramcs, sramwen);
    end
    tick();
    ap(1'b1, 3'd2, 16'h0014); hsel = 1'b0;
    tick();
    idle(); hwdata = 32'hFFFFFFFF;
    mid();
    tests++;
    if ({sramcs, sramwen} !== 5'b0) begin
      fails++; $display("FAIL na_hsel got cs=%b wen=%b exp 0", sramcs, sramwen);
    end
    tick();
    ap(1'b0, 3'd2, 16'h0014);
    tick();
    idle();
    mid();
    tests++;
    if (hrdata !== 32'hBEEF5600) begin
      fails++; $display("FAIL na_readback got %h exp %h", hrdata, 32'hBEEF5600);
    end
    tick();
  endtask

  task automatic test_reset_drops_buffer();
    ap(1'b1, 3'd2, 16'h0050);
    tick();
    idle(); hwdata = 32'h0BADF00D;
    tick();
    ap(1'b1, 3'd2, 16'h0050);
    tick();
    ap(1'b0, 3'd2, 16'h0010); hwdata = 32'h55555555;
    tick();
    hreset = 1'b1; idle(); hwdata = 32'h0;
    mid();
    tests++;
    if ({sramcs, sramwen} !== 5'b0) begin
      fails++; $display("FAIL t5_no_write_in_reset got cs=%b wen=%b exp 0", sramcs, sramwen);
    end
    tick();
    hreset = 1'b0;
    mid();
    tests++;
    if ({hreadyout, hresp, sramcs, sramwen, hrdata} !== {1'b1, 1'b0, 1'b0, 4'h0, 32'h0}) begin
      fails++; $display("FAIL t5_post_reset got rdy=%b resp=%b cs=%b wen=%b d=%h exp rdy=1 resp=0 cs=0 wen=0 d=0",
                        hreadyout, hresp, sramcs, sramwen, hrdata);
    end
    tick();
    ap(1'b0, 3'd2, 16'h0050);
    tick();
    idle();
    mid();
    tests++;
    if (hrdata !== 32'h0BADF00D) begin
      fails++; $display("FAIL t5_old_data got %h exp %h", hrdata, 32'h0BADF00D);
    end
    tick();
  endtask

`ifdef CMSDK_AHB_SRAM_ALIGN_ERR_EN
  task automatic test_align_err();
    ap(1'b0, 3'd2, 16'h0041);
    mid();
    tests++;
    if (sramcs !== 1'b0) begin
      fails++; $display("FAIL t6_no_access got cs=%b exp 0", sramcs);
    end
    tick();
    idle();
    mid();
    tests++;
    if ({hreadyout, hresp, sramcs} !== 3'b010) begin
      fails++; $display("FAIL t6_err1 got rdy=%b resp=%b cs=%b exp rdy=0 resp=1 cs=0", hreadyout, hresp, sramcs);
    end
    tick();
    ap(1'b0, 3'd2, 16'h0010);
    mid();
    tests++;
    if ({hreadyout, hresp, sramcs} !== 3'b111) begin
      fails++; $display("FAIL t6_err2 got rdy=%b resp=%b cs=%b exp rdy=1 resp=1 cs=1", hreadyout, hresp, sramcs);
    end
    tick();
    idle();
    mid();
    tests++;
    if ({hreadyout, hresp, hrdata} !== {1'b1, 1'b0, 32'hAAADBEEF}) begin
      fails++; $display("FAIL t6_after_err got rdy=%b resp=%b d=%h exp rdy=1 resp=0 d=aaadbeef", hreadyout, hresp, hrdata);
    end
    tick();
  endtask
`else
  task automatic test_align_err();
    ap(1'b0, 3'd2, 16'h0041);
    mid();
    tests++;
    if ({sramcs, sramaddr} !== {1'b1, 14'h10}) begin
      fails++; $display("FAIL t6_unaligned_read got cs=%b a=%h exp cs=1 a=10", sramcs, sramaddr);
    end
    tick();
    idle();
    mid();
    tests++;
    if ({hreadyout, hresp} !== 2'b10) begin
      fails++; $display("FAIL t6_okay_resp got rdy=%b resp=%b exp rdy=1 resp=0", hreadyout, hresp);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_word_write_read();
    test_buffer_forward();
    test_back_to_back();
    test_buffer_hold();
    test_byte_enables();
    test_not_accepted();
    test_reset_drops_buffer();
    test_align_err();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the test sequence completed");
    $fatal(1, "watchdog");
  end

endmodule
